// File: rtl/uart_echo_engine.sv
// UART echo engine: offsets each RX byte, buffers it in a FIFO, replays it to TX.
// Optional ECHO_STATS_EN adds rx_count / drop_count statistics outputs.
module uart_echo_engine #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int OFFSET       = 1,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           rx_data,
    input  logic                        rx_busy,
    input  logic                        tx_busy,
    input  logic                        clr_ovf,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
`ifdef ECHO_STATS_EN
    ,
    output logic [15:0]                 rx_count,
    output logic [15:0]                 drop_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [DATA_W-1:0] OFS      = DATA_W'(OFFSET);
    localparam logic [LW-1:0]     FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0]     TMO      = CW'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state;
    logic              busy_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              push;
    logic              pop;
    logic              full;
    logic              accept;
    logic              drop;

    assign push   = busy_q & ~rx_busy;
    assign full   = (fifo_level == FULL_LVL);
    assign pop    = (state == IDLE) && (fifo_level != '0) && !tx_busy;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= rx_data + OFS;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            busy_q <= rx_busy;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: ;
            endcase
            if (drop) overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            cnt      <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    cnt   <= CW'(1);
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // An unacknowledged byte is abandoned, not retried.
                    if (tx_busy) state <= WAIT_DONE;
                    else if (cnt == TMO) state <= IDLE;
                    else cnt <= cnt + 1'b1;
                end
                WAIT_DONE: begin
                    if (!tx_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ECHO_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (push) rx_count <= rx_count + 1'b1;
            if (drop) drop_count <= drop_count + 1'b1;
        end
    end
`endif

endmodule
